// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_hazard_ctrl
// Purpose  : Central sequencer for the LC-3b 5-stage pipeline registers
//            (IF_ID, ID_EX, EX_MEM, MEM_WB). Produces each register's Load
//            and Flush plus the PC load from D-mem/I-mem busy, load-use and
//            branch-mispredict events.
// Ports    : Clk, Reset (sync, active-high)
//            iIMemReq/iIMemResp, iDMemReq/iDMemResp   memory handshakes
//            iIdSR1Id/iIdSR2Id/iIdUsesSR1/iIdUsesSR2 decode-stage sources
//            iExDR/iExIsLoad                         ID_EX destination/load
//            iBrMispredict                           MEM-stage mispredict pulse
//            oLoadPC, oLoad{IFID,IDEX,EXMEM,MEMWB}, oFlush{IFID,IDEX,EXMEM,MEMWB}
//            oStallCycles/oFlushEvents               perf counters (PERF_W)
// Config   : HAZARD_PERF_EN defined -> saturating perf counters present,
//            otherwise both counter outputs are tied to zero.
// Revision : 1.0  initial release
// ============================================================================
module pipeline_hazard_ctrl #(
    parameter int REDIRECT_BUBBLES = 1,
    parameter int PERF_W           = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              iIMemReq,
    input  logic              iIMemResp,
    input  logic              iDMemReq,
    input  logic              iDMemResp,
    input  logic [2:0]        iIdSR1Id,
    input  logic [2:0]        iIdSR2Id,
    input  logic              iIdUsesSR1,
    input  logic              iIdUsesSR2,
    input  logic [2:0]        iExDR,
    input  logic              iExIsLoad,
    input  logic              iBrMispredict,
    output logic              oLoadPC,
    output logic              oLoadIFID,
    output logic              oLoadIDEX,
    output logic              oLoadEXMEM,
    output logic              oLoadMEMWB,
    output logic              oFlushIFID,
    output logic              oFlushIDEX,
    output logic              oFlushEXMEM,
    output logic              oFlushMEMWB,
    output logic [PERF_W-1:0] oStallCycles,
    output logic [PERF_W-1:0] oFlushEvents
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_DSTALL   = 2'd1,
        ST_REDIRECT = 2'd2
    } state_t;

    localparam logic [2:0] C_BUBBLES = 3'(REDIRECT_BUBBLES);

    state_t     r_state_q, w_state_d;
    logic [2:0] r_cnt_q,   w_cnt_d;
    logic       r_pend_q,  w_pend_d;

    logic w_dstall;
    logic w_mis_evt;
    logic w_redirect_act;
    logic w_load_use;
    logic w_istall;

    assign w_dstall  = iDMemReq & ~iDMemResp;
    // A mispredict seen while frozen is held and replayed on the first free cycle.
    assign w_mis_evt = iBrMispredict | r_pend_q;
    // The bubble counter survives a D-mem freeze, so the redirect window can
    // resume out of DSTALL as well as continue in REDIRECT.
    assign w_redirect_act = (r_state_q != ST_RUN) && (r_cnt_q != 3'd0);
    assign w_load_use = iExIsLoad & ((iIdUsesSR1 & (iIdSR1Id == iExDR)) |
                                     (iIdUsesSR2 & (iIdSR2Id == iExDR)));
    assign w_istall   = iIMemReq & ~iIMemResp;

    always_comb begin
        oLoadPC     = 1'b1;
        oLoadIFID   = 1'b1;
        oLoadIDEX   = 1'b1;
        oLoadEXMEM  = 1'b1;
        oLoadMEMWB  = 1'b1;
        oFlushIFID  = 1'b0;
        oFlushIDEX  = 1'b0;
        oFlushEXMEM = 1'b0;
        oFlushMEMWB = 1'b0;
        w_state_d   = ST_RUN;
        w_cnt_d     = r_cnt_q;
        w_pend_d    = r_pend_q;

        if (Reset) begin
            oLoadPC     = 1'b0;
            oFlushIFID  = 1'b1;
            oFlushIDEX  = 1'b1;
            oFlushEXMEM = 1'b1;
            oFlushMEMWB = 1'b1;
            w_cnt_d     = 3'd0;
            w_pend_d    = 1'b0;
        end else if (w_dstall) begin
            oLoadPC    = 1'b0;
            oLoadIFID  = 1'b0;
            oLoadIDEX  = 1'b0;
            oLoadEXMEM = 1'b0;
            oLoadMEMWB = 1'b0;
            w_state_d  = ST_DSTALL;
            w_pend_d   = r_pend_q | iBrMispredict;
        end else if (w_mis_evt) begin
            // Squash everything younger than MEM; MEM_WB keeps the branch.
            oFlushIFID  = 1'b1;
            oFlushIDEX  = 1'b1;
            oFlushEXMEM = 1'b1;
            w_pend_d    = 1'b0;
            w_cnt_d     = C_BUBBLES;
            w_state_d   = (C_BUBBLES != 3'd0) ? ST_REDIRECT : ST_RUN;
        end else if (w_redirect_act) begin
            oFlushIFID = 1'b1;
            w_cnt_d    = r_cnt_q - 3'd1;
            w_state_d  = (w_cnt_d != 3'd0) ? ST_REDIRECT : ST_RUN;
        end else if (w_load_use) begin
            // Hold PC and IF_ID, inject one bubble into ID_EX.
            oLoadPC    = 1'b0;
            oLoadIFID  = 1'b0;
            oFlushIDEX = 1'b1;
        end else if (w_istall) begin
            oLoadPC    = 1'b0;
            oFlushIFID = 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        r_state_q <= w_state_d;
        r_cnt_q   <= w_cnt_d;
        r_pend_q  <= w_pend_d;
    end

`ifdef HAZARD_PERF_EN
    logic [PERF_W-1:0] r_stall_q, w_stall_d;
    logic [PERF_W-1:0] r_flush_q, w_flush_d;
    logic              w_mis_apply;

    assign w_mis_apply = ~Reset & ~w_dstall & w_mis_evt;

    always_comb begin
        w_stall_d = r_stall_q;
        w_flush_d = r_flush_q;
        if (Reset) begin
            w_stall_d = '0;
            w_flush_d = '0;
        end else begin
            if (!oLoadPC && (r_stall_q != '1)) begin
                w_stall_d = r_stall_q + PERF_W'(1);
            end
            if (w_mis_apply && (r_flush_q != '1)) begin
                w_flush_d = r_flush_q + PERF_W'(1);
            end
        end
    end

    always_ff @(posedge Clk) begin
        r_stall_q <= w_stall_d;
        r_flush_q <= w_flush_d;
    end

    assign oStallCycles = r_stall_q;
    assign oFlushEvents = r_flush_q;
`else
    assign oStallCycles = '0;
    assign oFlushEvents = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_hazard_ctrl
// Purpose  : Self-checking bench for pipeline_hazard_ctrl. A vector table
//            covers reset, stalls, load-use and redirect; hand-written
//            sequences cover pending mispredicts, counter freeze/reload and
//            reset in the middle of multi-cycle events.
// Revision : 1.0  initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

    localparam int C_PW  = 3;
    localparam int C_MAX = 7;

    // Output word: {LoadPC, Load IFID/IDEX/EXMEM/MEMWB, Flush IFID/IDEX/EXMEM/MEMWB}
    localparam logic [8:0] C_RST = 9'b0_1111_1111;
    localparam logic [8:0] C_RUN = 9'b1_1111_0000;
    localparam logic [8:0] C_DST = 9'b0_0000_0000;
    localparam logic [8:0] C_MIS = 9'b1_1111_1110;
    localparam logic [8:0] C_RDR = 9'b1_1111_1000;
    localparam logic [8:0] C_LU  = 9'b0_0111_0100;
    localparam logic [8:0] C_IM  = 9'b0_1111_1000;

    typedef struct packed {
        logic       rst;
        logic       imreq;
        logic       imresp;
        logic       dmreq;
        logic       dmresp;
        logic [2:0] sr1;
        logic [2:0] sr2;
        logic       use1;
        logic       use2;
        logic [2:0] exdr;
        logic       exload;
        logic       mis;
    } in_t;

    typedef struct {
        in_t        in;
        logic [8:0] exp;
    } vec_t;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic            Reset, iIMemReq, iIMemResp, iDMemReq, iDMemResp;
    logic [2:0]      iIdSR1Id, iIdSR2Id, iExDR;
    logic            iIdUsesSR1, iIdUsesSR2, iExIsLoad, iBrMispredict;
    logic            oLoadPC, oLoadIFID, oLoadIDEX, oLoadEXMEM, oLoadMEMWB;
    logic            oFlushIFID, oFlushIDEX, oFlushEXMEM, oFlushMEMWB;
    logic [C_PW-1:0] oStallCycles, oFlushEvents;

    pipeline_hazard_ctrl #(
        .REDIRECT_BUBBLES (2),
        .PERF_W           (C_PW)
    ) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .iIMemReq      (iIMemReq),
        .iIMemResp     (iIMemResp),
        .iDMemReq      (iDMemReq),
        .iDMemResp     (iDMemResp),
        .iIdSR1Id      (iIdSR1Id),
        .iIdSR2Id      (iIdSR2Id),
        .iIdUsesSR1    (iIdUsesSR1),
        .iIdUsesSR2    (iIdUsesSR2),
        .iExDR         (iExDR),
        .iExIsLoad     (iExIsLoad),
        .iBrMispredict (iBrMispredict),
        .oLoadPC       (oLoadPC),
        .oLoadIFID     (oLoadIFID),
        .oLoadIDEX     (oLoadIDEX),
        .oLoadEXMEM    (oLoadEXMEM),
        .oLoadMEMWB    (oLoadMEMWB),
        .oFlushIFID    (oFlushIFID),
        .oFlushIDEX    (oFlushIDEX),
        .oFlushEXMEM   (oFlushEXMEM),
        .oFlushMEMWB   (oFlushMEMWB),
        .oStallCycles  (oStallCycles),
        .oFlushEvents  (oFlushEvents)
    );

    logic [8:0] sb_q[$];
    int         n_cmp  = 0;
    int         n_fail = 0;
    int         exp_stall = 0;
    int         exp_flush = 0;
    vec_t       tbl[16];

    in_t c_idle, c_r, c_ds, c_dr, c_mp, c_drmp, c_dsmp;
    in_t c_lu1, c_lu2, c_nlu, c_im, c_imr, c_luim, c_mplu;

    task automatic drive(input in_t v);
        Reset         = v.rst;
        iIMemReq      = v.imreq;
        iIMemResp     = v.imresp;
        iDMemReq      = v.dmreq;
        iDMemResp     = v.dmresp;
        iIdSR1Id      = v.sr1;
        iIdSR2Id      = v.sr2;
        iIdUsesSR1    = v.use1;
        iIdUsesSR2    = v.use2;
        iExDR         = v.exdr;
        iExIsLoad     = v.exload;
        iBrMispredict = v.mis;
    endtask

    // One clock: drive, queue the expectation, check mid-cycle, advance.
    task automatic step(input in_t v, input logic [8:0] e, input string nm);
        logic [8:0]      want;
        logic [8:0]      act;
        logic [C_PW-1:0] want_st, want_fl;
        drive(v);
        sb_q.push_back(e);
        @(negedge Clk);
        act = {oLoadPC, oLoadIFID, oLoadIDEX, oLoadEXMEM, oLoadMEMWB,
               oFlushIFID, oFlushIDEX, oFlushEXMEM, oFlushMEMWB};
        n_cmp++;
        if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: scoreboard empty, outputs=%b", nm, act);
        end else begin
            want = sb_q.pop_front();
            if (act !== want) begin
                n_fail++;
                $display("FAIL %s: outputs got %b expected %b", nm, act, want);
            end
        end
`ifdef HAZARD_PERF_EN
        want_st = C_PW'(exp_stall);
        want_fl = C_PW'(exp_flush);
`else
        want_st = '0;
        want_fl = '0;
`endif
        if (!v.rst) begin
            n_cmp++;
            if (oStallCycles !== want_st || oFlushEvents !== want_fl) begin
                n_fail++;
                $display("FAIL %s_perf: stall/flush got %0d/%0d expected %0d/%0d",
                         nm, oStallCycles, oFlushEvents, want_st, want_fl);
            end
        end
        if (v.rst) begin
            exp_stall = 0;
            exp_flush = 0;
        end else begin
            if (!e[8] && exp_stall < C_MAX) exp_stall++;
            if (e == C_MIS && exp_flush < C_MAX) exp_flush++;
        end
        @(posedge Clk);
        #1;
    endtask

    initial begin
        c_idle = '0;
        c_r    = c_idle; c_r.rst = 1'b1;
        c_ds   = c_idle; c_ds.dmreq = 1'b1;
        c_dr   = c_ds;   c_dr.dmresp = 1'b1;
        c_mp   = c_idle; c_mp.mis = 1'b1;
        c_drmp = c_dr;   c_drmp.mis = 1'b1;
        c_dsmp = c_ds;   c_dsmp.mis = 1'b1;
        c_lu1  = c_idle; c_lu1.exload = 1'b1; c_lu1.exdr = 3'd3;
                         c_lu1.use1 = 1'b1;   c_lu1.sr1 = 3'd3;
        c_lu2  = c_idle; c_lu2.exload = 1'b1; c_lu2.exdr = 3'd5;
                         c_lu2.use1 = 1'b1;   c_lu2.sr1 = 3'd2;
                         c_lu2.use2 = 1'b1;   c_lu2.sr2 = 3'd5;
        c_nlu  = c_lu1;  c_nlu.use1 = 1'b0;   c_nlu.use2 = 1'b1; c_nlu.sr2 = 3'd4;
        c_im   = c_idle; c_im.imreq = 1'b1;
        c_imr  = c_im;   c_imr.imresp = 1'b1;
        c_luim = c_lu1;  c_luim.imreq = 1'b1;
        c_mplu = c_lu1;  c_mplu.mis = 1'b1;

        tbl[0]  = '{c_r,    C_RST};
        tbl[1]  = '{c_idle, C_RUN};
        tbl[2]  = '{c_ds,   C_DST};
        tbl[3]  = '{c_ds,   C_DST};
        tbl[4]  = '{c_ds,   C_DST};
        tbl[5]  = '{c_dr,   C_RUN};
        tbl[6]  = '{c_lu1,  C_LU};
        tbl[7]  = '{c_idle, C_RUN};
        tbl[8]  = '{c_lu2,  C_LU};
        tbl[9]  = '{c_nlu,  C_RUN};
        tbl[10] = '{c_im,   C_IM};
        tbl[11] = '{c_imr,  C_RUN};
        tbl[12] = '{c_mp,   C_MIS};
        tbl[13] = '{c_idle, C_RDR};
        tbl[14] = '{c_idle, C_RDR};
        tbl[15] = '{c_idle, C_RUN};

        drive(c_idle);
        @(posedge Clk);
        #1;

        for (int i = 0; i < 16; i++) begin
            step(tbl[i].in, tbl[i].exp, $sformatf("vec%0d", i));
        end

        // Mispredict in the 2nd cycle of a 4-cycle D-mem stall.
        step(c_ds,   C_DST, "pend_s0");
        step(c_dsmp, C_DST, "pend_s1");
        step(c_ds,   C_DST, "pend_s2");
        step(c_ds,   C_DST, "pend_s3");
        step(c_dr,   C_MIS, "pend_resp");
        step(c_idle, C_RDR, "pend_b1");
        step(c_idle, C_RDR, "pend_b2");
        step(c_idle, C_RUN, "pend_run");

        // Mispredict arriving on the response cycle itself.
        step(c_ds,   C_DST, "coinc_s0");
        step(c_drmp, C_MIS, "coinc_resp");
        step(c_idle, C_RDR, "coinc_b1");
        step(c_idle, C_RDR, "coinc_b2");
        step(c_idle, C_RUN, "coinc_run");

        // D-mem stall freezes the redirect counter.
        step(c_mp,   C_MIS, "frz_mis");
        step(c_idle, C_RDR, "frz_b1");
        step(c_ds,   C_DST, "frz_s0");
        step(c_ds,   C_DST, "frz_s1");
        step(c_dr,   C_RDR, "frz_b2");
        step(c_idle, C_RUN, "frz_run");

        // New mispredict inside REDIRECT reloads the counter.
        step(c_mp,   C_MIS, "rld_mis0");
        step(c_idle, C_RDR, "rld_b1");
        step(c_mp,   C_MIS, "rld_mis1");
        step(c_idle, C_RDR, "rld_b1b");
        step(c_idle, C_RDR, "rld_b2b");
        step(c_idle, C_RUN, "rld_run");

        // Priority: load-use over I-mem stall, mispredict over load-use.
        step(c_luim, C_LU,  "prio_lu_im");
        step(c_mplu, C_MIS, "prio_mis_lu");
        step(c_idle, C_RDR, "prio_b1");
        step(c_idle, C_RDR, "prio_b2");
        step(c_idle, C_RUN, "prio_run");

        // Reset mid-stall drops the pending mispredict.
        step(c_ds,   C_DST, "rst_s0");
        step(c_dsmp, C_DST, "rst_s1");
        step(c_r,    C_RST, "rst_in_stall");
        step(c_idle, C_RUN, "rst_after_stall");
        step(c_idle, C_RUN, "rst_after_stall2");

        // Reset mid-REDIRECT drops the bubble window.
        step(c_mp,   C_MIS, "rstr_mis");
        step(c_r,    C_RST, "rst_in_redirect");
        step(c_idle, C_RUN, "rst_after_redir");

        // Push the stall counter into saturation.
        for (int i = 0; i < 9; i++) begin
            step(c_im, C_IM, $sformatf("sat%0d", i));
        end
        step(c_idle, C_RUN, "sat_end");

        n_cmp++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: %0d entries left, expected 0", sb_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
